spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Tester-side SPI master that drives an SPI slave DUT.
- Accepts a command word from the tester control logic and shifts it out MSB first.
- Then clocks back a response word MSB first and presents it with a one-cycle done pulse.
- Generates spi_clk, cs_n and mosi from the system clock sclk. Protocol is fixed: 8-bit command, then 24-bit response whose MSB is valid after the rising edge that follows the last command bit.

Parameters:
- HALF_DIV, 4: sclk cycles per spi_clk half-period; legal range 1..255.
- CMD_W, 8: command width in bits.
- RSP_W, 24: response width in bits.

Ports:
- sclk  in  1  system clock; all logic rises on posedge sclk.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  transfer request; sampled only in IDLE.
- cmd_in  in  CMD_W  command word; captured on the cycle start is accepted.
- busy  out  1  high from the accept cycle until the cycle before done.
- done  out  1  one-cycle pulse; rsp_data is valid from this cycle on.
- rsp_data  out  RSP_W  last received response; held until the next done.
- spi_clk  out  1  serial clock; idles low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.
- cs_n  out  1  chip select, active-low; idles high.

Behaviour:
- Reset values: busy=0, done=0, rsp_data=0, spi_clk=0, mosi=0, cs_n=1, state=IDLE, counters=0.
- Reset asserted mid-transfer aborts at once to the reset values. The slave sees cs_n rise and resets its own bit counter.
- All outputs are registered. Half-period counter hc counts 0..HALF_DIV-1; edge counter n counts spi_clk rising edges, 1-based.
- IDLE:
  - If start=1: latch cmd_in into a shift register, cs_n<=0, mosi<=cmd_in[CMD_W-1], busy<=1, hc<=0, go to SETUP.
  - start while not in IDLE is ignored; no queueing.
- SETUP: wait HALF_DIV cycles with cs_n low and spi_clk low, then drive spi_clk<=1 (rise n=1) and go to HIGH.
- HIGH: after HALF_DIV cycles, drive spi_clk<=0 (fall n), go to LOW. In that same sclk cycle:
  - if n < CMD_W: mosi <= next command bit;
  - if n >= CMD_W: mosi <= 0;
  - if CMD_W+1 <= n <= CMD_W+RSP_W: sample miso into the response shift register, shifting left with the new bit entering at LSB.
- LOW:
  - If n = CMD_W+RSP_W: wait HALF_DIV cycles, then go to HOLD.
  - Otherwise: after HALF_DIV cycles, spi_clk<=1, n<=n+1, go to HIGH.
- HOLD: cs_n stays low for HALF_DIV cycles, then cs_n<=1 and go to GAP.
- GAP: cs_n high for HALF_DIV cycles. On the final GAP cycle:
  - rsp_data <= response shift register;
  - done<=1 for exactly one cycle;
  - busy<=0;
  - go to IDLE.
  - A start arriving in the same cycle as done is not accepted; it is accepted on the following cycle.
- Slave timing this implements:
  - the slave shifts in mosi on spi_clk rises 1..CMD_W;
  - it loads its response on rise CMD_W+1 and shifts on later rises;
  - the master samples on falls CMD_W+1..CMD_W+RSP_W, each a full half-period after the slave updates.
- miso is sampled directly without a synchronizer. It is stable for HALF_DIV sclk cycles before each sample point.
- Transfer length in sclk cycles from the accept cycle to done = HALF_DIV*(2*(CMD_W+RSP_W)+3) + 1.
  - Default: 4*67+1 = 269.
- Total spi_clk rising edges per transfer = CMD_W+RSP_W (default 32). spi_clk never toggles while cs_n is high.

Test Plan:
- Default parameters, cmd_in=0x03 with start pulse, bench slave model computes cmd*cmd:
  - rsp_data=0x000009 at done;
  - done is high exactly 1 cycle, 269 cycles after accept;
  - 32 spi_clk rises counted.
- cmd_in=0xFF -> rsp_data=0x00FE01. cmd_in=0x00 -> rsp_data=0x000000. Back-to-back: start held high continuously -> second transfer accepted exactly 1 cycle after first done.
- mosi check, cmd_in=0xA5: bits captured on spi_clk rises 1..8 read 1,0,1,0,0,1,0,1; mosi=0 on rises 9..32; cs_n low throughout all 32 rises.
- start pulsed while busy (cmd_in=0x11 at cycle 50) -> ignored. rsp_data is the original command's square and only one done is produced.
- HALF_DIV=1, cmd_in=0x10 -> rsp_data=0x000100; done 68 cycles after accept; spi_clk toggles every sclk cycle.
- reset_n pulsed low at rise 12 -> same cycle: cs_n=1, spi_clk=0, busy=0, rsp_data=0. Next start with cmd_in=0x02 -> rsp_data=0x000004.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Tester-side SPI master: shifts out a CMD_W-bit command MSB first, then clocks
// back an RSP_W-bit response and presents it with a one-cycle done pulse.
module spi_master_ctrl #(
  parameter int HALF_DIV = 4,
  parameter int CMD_W    = 8,
  parameter int RSP_W    = 24
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CMD_W-1:0] cmd_in,
  output logic             busy,
  output logic             done,
  output logic [RSP_W-1:0] rsp_data,
  output logic             spi_clk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int TOT = CMD_W + RSP_W;
  localparam int NW  = $clog2(TOT + 1);
  localparam logic [7:0]    HC_LAST = 8'(HALF_DIV - 1);
  localparam logic [NW-1:0] N_CMD   = NW'(CMD_W);
  localparam logic [NW-1:0] N_TOT   = NW'(TOT);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hc_q, hc_d;
  logic [NW-1:0]      n_q, n_d;
  logic [CMD_W-2:0]   cmd_sh_q, cmd_sh_d;
  logic [RSP_W-1:0]   rsp_sh_q, rsp_sh_d;
  logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               spi_clk_q, spi_clk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               hc_end;

  assign hc_end = (hc_q == HC_LAST);

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hc_q       <= '0;
      n_q        <= '0;
      cmd_sh_q   <= '0;
      rsp_sh_q   <= '0;
      rsp_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      n_q        <= n_d;
      cmd_sh_q   <= cmd_sh_d;
      rsp_sh_q   <= rsp_sh_d;
      rsp_data_q <= rsp_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      spi_clk_q  <= spi_clk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hc_d       = hc_end ? 8'd0 : hc_q + 8'd1;
    n_d        = n_q;
    cmd_sh_d   = cmd_sh_q;
    rsp_sh_d   = rsp_sh_q;
    rsp_data_d = rsp_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    spi_clk_d  = spi_clk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    unique case (state_q)
      IDLE: begin
        hc_d = 8'd0;
        // A start coinciding with done is deferred by one cycle.
        if (start && !done_q) begin
          cmd_sh_d = cmd_in[CMD_W-2:0];
          mosi_d   = cmd_in[CMD_W-1];
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (hc_end) begin
          spi_clk_d = 1'b1;
          n_d       = NW'(1);
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (hc_end) begin
          spi_clk_d = 1'b0;
          state_d   = LOW;
          if (n_q < N_CMD) begin
            mosi_d   = cmd_sh_q[CMD_W-2];
            cmd_sh_d = cmd_sh_q << 1;
          end else begin
            mosi_d = 1'b0;
          end
          // Response bits are sampled on falls, a half-period after the slave shifts.
          if (n_q > N_CMD) begin
            rsp_sh_d = {rsp_sh_q[RSP_W-2:0], miso};
          end
        end
      end
      LOW: begin
        if (hc_end) begin
          if (n_q == N_TOT) begin
            state_d = HOLD;
          end else begin
            spi_clk_d = 1'b1;
            n_d       = n_q + NW'(1);
            state_d   = HIGH;
          end
        end
      end
      HOLD: begin
        if (hc_end) begin
          cs_n_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (hc_end) begin
          rsp_data_d = rsp_sh_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          n_d        = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rsp_data = rsp_data_q;
  assign spi_clk  = spi_clk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a behavioural slave returns cmd*cmd and
// each step compares DUT outputs against hand-computed values.
module tb_spi_master_ctrl;

  logic        sclk;
  logic        reset_n;
  logic        start, start1;
  logic [7:0]  cmd_in, cmd_in1;
  logic        busy, busy1, done, done1;
  logic [23:0] rsp_data, rsp_data1;
  logic        spi_clk, spi_clk1, mosi, mosi1, miso, miso1, cs_n, cs_n1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_master_ctrl u_dut (
    .sclk(sclk), .reset_n(reset_n), .start(start), .cmd_in(cmd_in),
    .busy(busy), .done(done), .rsp_data(rsp_data), .spi_clk(spi_clk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_ctrl #(.HALF_DIV(1)) u_dut1 (
    .sclk(sclk), .reset_n(reset_n), .start(start1), .cmd_in(cmd_in1),
    .busy(busy1), .done(done1), .rsp_data(rsp_data1), .spi_clk(spi_clk1),
    .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc++;

  // Slave model for the default instance: shifts mosi on rises 1..8,
  // loads cmd*cmd on rise 9, shifts the response out on later rises.
  int          s_cnt = 0;
  logic [7:0]  s_in = '0;
  logic [23:0] s_rsp = '0;
  always @(posedge spi_clk or posedge cs_n) begin
    if (cs_n) s_cnt = 0;
    else begin
      s_cnt++;
      if (s_cnt <= 8) s_in = {s_in[6:0], mosi};
      else if (s_cnt == 9) s_rsp = 24'(s_in) * 24'(s_in);
      else s_rsp = s_rsp << 1;
    end
  end
  assign miso = s_rsp[23];

  int          s1_cnt = 0;
  logic [7:0]  s1_in = '0;
  logic [23:0] s1_rsp = '0;
  always @(posedge spi_clk1 or posedge cs_n1) begin
    if (cs_n1) s1_cnt = 0;
    else begin
      s1_cnt++;
      if (s1_cnt <= 8) s1_in = {s1_in[6:0], mosi1};
      else if (s1_cnt == 9) s1_rsp = 24'(s1_in) * 24'(s1_in);
      else s1_rsp = s1_rsp << 1;
    end
  end
  assign miso1 = s1_rsp[23];

  // Bus monitors.
  int          rises_total = 0;
  logic [31:0] mosi_cap = '0;
  bit          cs_bad = 0;
  always @(posedge spi_clk) begin
    rises_total++;
    mosi_cap = {mosi_cap[30:0], mosi};
    if (cs_n) cs_bad = 1;
  end

  int r1_total = 0;
  int r1_first = 0;
  int f1_last = 0;
  always @(posedge spi_clk1) begin
    r1_total++;
    if (r1_total == 1) r1_first = cyc;
  end
  always @(negedge spi_clk1) f1_last = cyc;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sel, input string tag, output int dc);
    int k = 0;
    while (((sel ? done1 : done) !== 1'b1) && k < 1000) begin
      tick();
      k++;
    end
    check(tag, 32'(sel ? done1 : done), 32'd1);
    dc = cyc;
  endtask

  task automatic xfer(input logic [7:0] c, input logic [23:0] exp_rsp, input string tag);
    int acc, dc, base;
    base    = rises_total;
    cmd_in  = c;
    start   = 1'b1;
    acc     = cyc;
    tick();
    start   = 1'b0;
    wait_done(1'b0, {tag, "_done"}, dc);
    check({tag, "_rsp"}, 32'(rsp_data), 32'(exp_rsp));
    check({tag, "_latency"}, 32'(dc - acc), 32'd269);
    check({tag, "_rises"}, 32'(rises_total - base), 32'd32);
    $display("xfer %s cmd=%02h rsp=%06h latency=%0d", tag, c, rsp_data, dc - acc);
    tick();
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int acc, dc, d1, dc2, base, extra, k;
    reset_n = 1'b0; start = 1'b0; cmd_in = '0; start1 = 1'b0; cmd_in1 = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rsp", 32'(rsp_data), 32'd0);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    reset_n = 1'b1;
    tick();

    xfer(8'h03, 24'h000009, "cmd03");
    xfer(8'hFF, 24'h00FE01, "cmdFF");
    xfer(8'h00, 24'h000000, "cmd00");

    // Back-to-back with start held high.
    cmd_in = 8'h07;
    start  = 1'b1;
    acc    = cyc;
    wait_done(1'b0, "b2b_done1", d1);
    check("b2b_rsp1", 32'(rsp_data), 32'h31);
    check("b2b_lat1", 32'(d1 - acc), 32'd269);
    $display("xfer b2b_1 cmd=07 rsp=%06h latency=%0d", rsp_data, d1 - acc);
    cmd_in = 8'h05;
    tick();
    check("b2b_busy_done_next", 32'(busy), 32'd0);
    tick();
    check("b2b_busy_accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1'b0, "b2b_done2", dc2);
    check("b2b_rsp2", 32'(rsp_data), 32'h19);
    check("b2b_lat2", 32'(dc2 - (d1 + 1)), 32'd269);
    $display("xfer b2b_2 cmd=05 rsp=%06h latency=%0d", rsp_data, dc2 - (d1 + 1));
    tick();

    // mosi pattern and chip-select coverage.
    xfer(8'hA5, 24'h006A59, "cmdA5");
    check("mosi_bits", mosi_cap, 32'hA500_0000);
    check("cs_low_at_rises", 32'(cs_bad), 32'd0);

    // start pulsed while busy is ignored.
    cmd_in = 8'h09;
    start  = 1'b1;
    acc    = cyc;
    tick();
    start  = 1'b0;
    while (cyc < acc + 50) tick();
    cmd_in = 8'h11;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cmd_in = 8'h00;
    wait_done(1'b0, "ign_done", dc);
    check("ign_rsp", 32'(rsp_data), 32'h51);
    check("ign_lat", 32'(dc - acc), 32'd269);
    $display("xfer ignore cmd=09 rsp=%06h latency=%0d", rsp_data, dc - acc);
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) extra++;
    end
    check("ign_extra_done", 32'(extra), 32'd0);

    // HALF_DIV=1 instance.
    cmd_in1 = 8'h10;
    start1  = 1'b1;
    acc     = cyc;
    tick();
    start1  = 1'b0;
    wait_done(1'b1, "hd1_done", dc);
    check("hd1_rsp", 32'(rsp_data1), 32'h000100);
    check("hd1_lat", 32'(dc - acc), 32'd68);
    check("hd1_rises", 32'(r1_total), 32'd32);
    check("hd1_toggle_span", 32'(f1_last - r1_first), 32'd63);
    $display("xfer hd1 cmd=10 rsp=%06h latency=%0d", rsp_data1, dc - acc);
    tick();

    // Reset in the middle of a transfer at rise 12.
    base   = rises_total;
    cmd_in = 8'h0C;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    k = 0;
    while ((rises_total - base) < 12 && k < 1000) begin
      tick();
      k++;
    end
    check("rst_mid_reached_rise12", 32'(rises_total - base), 32'd12);
    reset_n = 1'b0;
    #1;
    check("rst_mid_cs_n", 32'(cs_n), 32'd1);
    check("rst_mid_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rsp", 32'(rsp_data), 32'd0);
    $display("xfer reset_abort cmd=0c cs_n=%0b busy=%0b", cs_n, busy);
    #2;
    reset_n = 1'b1;
    tick();
    xfer(8'h02, 24'h000004, "cmd02");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
